// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage state encoding.
package cpu_pkg;
  localparam int PC_W      = 12;
  localparam int INSTR_W   = 19;
  localparam int RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs from decode, imem read data, and the PC/IF-ID/status outputs.
// Control inputs are level signals sampled on each rising clk edge; there is no backpressure handshake.
interface fetch_if
  import cpu_pkg::*;
#(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);
  logic               start;
  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirectTarget;
  logic               callEn;
  logic [PC_W-1:0]    linkAddr;
  logic               retEn;
  logic [PC_W-1:0]    retTarget;
  logic               halt;
  logic [INSTR_W-1:0] imemData;
  logic [PC_W-1:0]    imemAddr;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ifidInstr;
  logic [PC_W-1:0]    ifidPc;
  logic               ifidValid;
  logic               running;
  logic               rasErr;
  fetch_state_e       state;

  modport master (
    output start, stall, redirect, redirectTarget, callEn, linkAddr,
           retEn, retTarget, halt, imemData,
    input  imemAddr, pc, ifidInstr, ifidPc, ifidValid, running, rasErr, state
  );

  modport slave (
    input  start, stall, redirect, redirectTarget, callEn, linkAddr,
           retEn, retTarget, halt, imemData,
    output imemAddr, pc, ifidInstr, ifidPc, ifidValid, running, rasErr, state
  );
endinterface

// File: rtl/return_stack.sv
// Circular return-address LIFO: push, pop, or replace-top when both strobes are set.
// Push when full overwrites the oldest entry; pop when empty yields 0. err is a one-cycle combinational pulse.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         err,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] sp;
  logic [AW:0]   count;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign top   = empty ? '0 : mem[sp - AW'(1)];
  assign err   = (push && !pop && full) || (pop && empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          sp <= sp + AW'(1);
          if (!full) count <= count + (AW+1)'(1);
        end
        2'b01: begin
          if (!empty) begin
            sp    <= sp - AW'(1);
            count <= count - (AW+1)'(1);
          end
        end
        2'b11: begin
          // Replace-top keeps depth; on an empty stack it degenerates into a plain push.
          if (empty) begin
            sp    <= sp + AW'(1);
            count <= (AW+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      if (pop && !empty) mem[sp - AW'(1)] <= din;
      else               mem[sp]          <= din;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, next-PC priority mux, IF/ID register and fetch FSM.
// Define FETCH_RAS_EN to build the hardware return-address stack; otherwise retEn uses retTarget.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int PC_W      = cpu_pkg::PC_W,
  parameter int INSTR_W   = cpu_pkg::INSTR_W,
  parameter int RAS_DEPTH = cpu_pkg::RAS_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  fetch_if.slave bus
);
  fetch_state_e       state;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ifid_instr_q;
  logic [PC_W-1:0]    ifid_pc_q;
  logic               ifid_valid_q;
  logic               running_q;
  logic [PC_W-1:0]    ret_target;

  // Stack side effects only happen while actively fetching; stall does not gate them.
  logic ras_active;
  assign ras_active = (state == RUN) && !bus.halt;

`ifdef FETCH_RAS_EN
  logic            ras_err;
  logic            ras_err_q;
  logic            unused_ras_empty;
  logic            unused_ras_full;
  logic [PC_W-1:0] unused_ret_target;

  assign unused_ret_target = bus.retTarget;

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_active && bus.callEn),
    .pop   (ras_active && bus.retEn),
    .din   (bus.linkAddr),
    .top   (ret_target),
    .err   (ras_err),
    .empty (unused_ras_empty),
    .full  (unused_ras_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ras_err_q <= 1'b0;
    else     ras_err_q <= ras_err_q | ras_err;
  end

  assign bus.rasErr = ras_err_q;
`else
  logic            unused_call_en;
  logic [PC_W-1:0] unused_link_addr;
  logic            unused_ras_active;

  assign unused_call_en    = bus.callEn;
  assign unused_link_addr  = bus.linkAddr;
  assign unused_ras_active = ras_active;
  assign ret_target        = bus.retTarget;
  assign bus.rasErr        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc_q         <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.halt) begin
            state        <= HALTED;
            running_q    <= 1'b0;
            ifid_valid_q <= 1'b0;
          end else if (bus.retEn) begin
            pc_q         <= ret_target;
            ifid_valid_q <= 1'b0;
          end else if (bus.redirect) begin
            pc_q         <= bus.redirectTarget;
            ifid_valid_q <= 1'b0;
          end else if (!bus.stall) begin
            ifid_instr_q <= bus.imemData;
            ifid_pc_q    <= pc_q;
            ifid_valid_q <= 1'b1;
            pc_q         <= pc_q + PC_W'(1);
          end
        end
        default: ; // HALTED is left only through rst
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.imemAddr  = pc_q;
  assign bus.ifidInstr = ifid_instr_q;
  assign bus.ifidPc    = ifid_pc_q;
  assign bus.ifidValid = ifid_valid_q;
  assign bus.running   = running_q;
  assign bus.state     = state;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns address+100.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imemData = INSTR_W'(bus.imemAddr) + INSTR_W'(100);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.stall = 0; bus.redirect = 0; bus.redirectTarget = '0;
    bus.callEn = 0; bus.linkAddr = '0; bus.retEn = 0; bus.retTarget = '0; bus.halt = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.pc !== 12'h000) begin errors++; $display("FAIL reset_pc got %0h exp 0", bus.pc); end
    checks++; if (bus.imemAddr !== 12'h000) begin errors++; $display("FAIL reset_imemaddr got %0h exp 0", bus.imemAddr); end
    checks++; if (bus.ifidInstr !== 19'h0) begin errors++; $display("FAIL reset_instr got %0h exp 0", bus.ifidInstr); end
    checks++; if (bus.ifidPc !== 12'h000) begin errors++; $display("FAIL reset_ifidpc got %0h exp 0", bus.ifidPc); end
    checks++; if (bus.ifidValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.ifidValid); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got %0b exp 0", bus.running); end
    checks++; if (bus.rasErr !== 1'b0) begin errors++; $display("FAIL reset_raserr got %0b exp 0", bus.rasErr); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", bus.state); end
    tick();
    checks++; if (bus.pc !== 12'h000 || bus.ifidValid !== 1'b0) begin errors++; $display("FAIL idle_hold got pc=%0h v=%0b exp pc=0 v=0", bus.pc, bus.ifidValid); end
  endtask

  task automatic test_start();
    start_run();
    checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL start_running got %0b exp 1", bus.running); end
    checks++; if (bus.pc !== 12'h000 || bus.ifidValid !== 1'b0) begin errors++; $display("FAIL start_edge got pc=%0h v=%0b exp pc=0 v=0", bus.pc, bus.ifidValid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.ifidInstr !== 19'(100 + i) || bus.ifidPc !== 12'(i) || bus.ifidValid !== 1'b1 || bus.pc !== 12'(i + 1)) begin
        errors++;
        $display("FAIL seq_fetch%0d got instr=%0d ifidpc=%0d v=%0b pc=%0d exp instr=%0d ifidpc=%0d v=1 pc=%0d",
                 i, bus.ifidInstr, bus.ifidPc, bus.ifidValid, bus.pc, 100 + i, i, i + 1);
      end
    end
  endtask

  task automatic test_stall();
    tick();
    tick();
    checks++; if (bus.pc !== 12'd5) begin errors++; $display("FAIL stall_setup_pc got %0d exp 5", bus.pc); end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.pc !== 12'd5 || bus.ifidPc !== 12'd4 || bus.ifidInstr !== 19'd104 || bus.ifidValid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d got pc=%0d ifidpc=%0d instr=%0d v=%0b exp pc=5 ifidpc=4 instr=104 v=1",
                 i, bus.pc, bus.ifidPc, bus.ifidInstr, bus.ifidValid);
      end
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.ifidPc !== 12'd5 || bus.ifidInstr !== 19'd105 || bus.pc !== 12'd6) begin
      errors++;
      $display("FAIL stall_resume got ifidpc=%0d instr=%0d pc=%0d exp ifidpc=5 instr=105 pc=6", bus.ifidPc, bus.ifidInstr, bus.pc);
    end
  endtask

  task automatic test_redirect();
    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirectTarget = 12'h200;
    tick();
    bus.stall = 1'b0; bus.redirect = 1'b0;
    checks++; if (bus.pc !== 12'h200 || bus.ifidValid !== 1'b0) begin errors++; $display("FAIL redirect_bubble got pc=%0h v=%0b exp pc=200 v=0", bus.pc, bus.ifidValid); end
    tick();
    checks++;
    if (bus.ifidPc !== 12'h200 || bus.ifidInstr !== 19'd612 || bus.ifidValid !== 1'b1 || bus.pc !== 12'h201) begin
      errors++;
      $display("FAIL redirect_target got ifidpc=%0h instr=%0d v=%0b pc=%0h exp ifidpc=200 instr=612 v=1 pc=201",
               bus.ifidPc, bus.ifidInstr, bus.ifidValid, bus.pc);
    end
  endtask

  task automatic test_wrap();
    bus.redirect = 1'b1; bus.redirectTarget = 12'hFFF;
    tick();
    bus.redirect = 1'b0;
    tick();
    checks++;
    if (bus.ifidPc !== 12'hFFF || bus.ifidInstr !== 19'd4195 || bus.pc !== 12'h000) begin
      errors++;
      $display("FAIL pc_wrap got ifidpc=%0h instr=%0d pc=%0h exp ifidpc=fff instr=4195 pc=0", bus.ifidPc, bus.ifidInstr, bus.pc);
    end
  endtask

`ifdef FETCH_RAS_EN
  task automatic test_ras_basic();
    bus.callEn = 1'b1; bus.linkAddr = 12'h010;
    tick();
    bus.linkAddr = 12'h020;
    tick();
    bus.callEn = 1'b0; bus.retEn = 1'b1;
    bus.retTarget = 12'h7FF;
    tick();
    checks++; if (bus.pc !== 12'h020 || bus.ifidValid !== 1'b0) begin errors++; $display("FAIL ret1 got pc=%0h v=%0b exp pc=20 v=0", bus.pc, bus.ifidValid); end
    tick();
    checks++; if (bus.pc !== 12'h010 || bus.rasErr !== 1'b0) begin errors++; $display("FAIL ret2 got pc=%0h err=%0b exp pc=10 err=0", bus.pc, bus.rasErr); end
    tick();
    bus.retEn = 1'b0;
    checks++; if (bus.pc !== 12'h000 || bus.rasErr !== 1'b1) begin errors++; $display("FAIL ret_underflow got pc=%0h err=%0b exp pc=0 err=1", bus.pc, bus.rasErr); end
  endtask

  task automatic test_ras_overflow();
    do_reset();
    start_run();
    for (int i = 1; i <= 9; i++) begin
      bus.callEn = 1'b1; bus.linkAddr = 12'(12'h100 + i);
      tick();
      if (i == 8) begin
        checks++; if (bus.rasErr !== 1'b0) begin errors++; $display("FAIL ras_full_no_err got %0b exp 0", bus.rasErr); end
      end
    end
    bus.callEn = 1'b0;
    checks++; if (bus.rasErr !== 1'b1) begin errors++; $display("FAIL ras_overflow_err got %0b exp 1", bus.rasErr); end
    bus.retEn = 1'b1;
    tick();
    checks++; if (bus.pc !== 12'h109) begin errors++; $display("FAIL ras_pop_ninth got %0h exp 109", bus.pc); end
    tick();
    bus.retEn = 1'b0;
    checks++; if (bus.pc !== 12'h108) begin errors++; $display("FAIL ras_pop_eighth got %0h exp 108", bus.pc); end
  endtask
`else
  task automatic test_ret_target();
    bus.callEn = 1'b1; bus.linkAddr = 12'h055;
    tick();
    bus.callEn = 1'b0; bus.retEn = 1'b1; bus.retTarget = 12'h0AB;
    tick();
    bus.retEn = 1'b0;
    checks++; if (bus.pc !== 12'h0AB || bus.ifidValid !== 1'b0) begin errors++; $display("FAIL ret_target got pc=%0h v=%0b exp pc=ab v=0", bus.pc, bus.ifidValid); end
    checks++; if (bus.rasErr !== 1'b0) begin errors++; $display("FAIL raserr_tied got %0b exp 0", bus.rasErr); end
    bus.retEn = 1'b1; bus.retTarget = 12'h0CD; bus.redirect = 1'b1; bus.redirectTarget = 12'h300;
    tick();
    bus.retEn = 1'b0; bus.redirect = 1'b0;
    checks++; if (bus.pc !== 12'h0CD) begin errors++; $display("FAIL ret_over_redirect got pc=%0h exp cd", bus.pc); end
  endtask
`endif

  task automatic test_halt();
    bus.redirect = 1'b1; bus.redirectTarget = 12'h009;
    tick();
    bus.redirect = 1'b0;
    tick();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    checks++;
    if (bus.running !== 1'b0 || bus.ifidValid !== 1'b0 || bus.pc !== 12'h00A || bus.state !== HALTED) begin
      errors++;
      $display("FAIL halt got run=%0b v=%0b pc=%0h st=%0d exp run=0 v=0 pc=a st=HALTED", bus.running, bus.ifidValid, bus.pc, bus.state);
    end
    start_run();
    tick();
    checks++;
    if (bus.running !== 1'b0 || bus.ifidValid !== 1'b0 || bus.pc !== 12'h00A) begin
      errors++;
      $display("FAIL halt_start_ignored got run=%0b v=%0b pc=%0h exp run=0 v=0 pc=a", bus.running, bus.ifidValid, bus.pc);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pc !== 12'h000 || bus.ifidPc !== 12'h000 || bus.ifidInstr !== 19'h0 || bus.ifidValid !== 1'b0 ||
        bus.running !== 1'b0 || bus.rasErr !== 1'b0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL async_reset got pc=%0h ifidpc=%0h instr=%0h v=%0b run=%0b err=%0b st=%0d exp all 0 IDLE",
               bus.pc, bus.ifidPc, bus.ifidInstr, bus.ifidValid, bus.running, bus.rasErr, bus.state);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clear_inputs();
    test_reset();
    test_start();
    test_stall();
    test_redirect();
    test_wrap();
`ifdef FETCH_RAS_EN
    test_ras_basic();
    test_ras_overflow();
`else
    test_ret_target();
`endif
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
